reg_dst_data_mux: RTL and testbench

- Write-back data selector for the 16-bit CPU register file.
- Picks one of four candidate write-data sources (a, b, c, d) with a 2-bit select and presents the result to the register file write port.
- Primary output `out` is purely combinational, with zero latency.
- A registered copy `out_q` is provided for pipelined write-back stages.

---
 rtl/reg_dst_data_mux_pkg.sv | 17 +
 rtl/reg_dst_data_mux_if.sv | 41 ++++
 rtl/reg_dst_data_mux.sv | 77 +++++++
 tb/tb_reg_dst_data_mux.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/reg_dst_data_mux_pkg.sv
// Purpose : shared types and constants for the register write-back data selector.
// Contents: DATA_W default width, SEL_* source-select encodings, sel_t select type.
// Optional: REG_DST_DATA_MUX_ZERO_FLAG_EN (used by the interface and top, not here).
package reg_dst_data_mux_pkg;

  // Default data width of the register file write port.
  localparam int DATA_W = 16;

  // Source-select type and encodings.
  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage : reg_dst_data_mux_pkg

// File: rtl/reg_dst_data_mux_if.sv
// Purpose : bundles the selector's data sources, select and results into one bus.
// Ports   : a/b/c/d/sel driven by master; out/out_q/sel_q (and zero/zero_q) driven by slave.
// Optional: REG_DST_DATA_MUX_ZERO_FLAG_EN adds zero (comb) and zero_q (registered) flags.
interface reg_dst_data_mux_if
  import reg_dst_data_mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  sel_t             sel;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  sel_t             sel_q;
`ifdef REG_DST_DATA_MUX_ZERO_FLAG_EN
  logic             zero;
  logic             zero_q;
`endif

  // Master side: the pipeline stage that offers the candidate write data.
  modport master (
    output a, b, c, d, sel,
`ifdef REG_DST_DATA_MUX_ZERO_FLAG_EN
    input  zero, zero_q,
`endif
    input  out, out_q, sel_q
  );

  // Slave side: the selector itself.
  modport slave (
    input  a, b, c, d, sel,
`ifdef REG_DST_DATA_MUX_ZERO_FLAG_EN
    output zero, zero_q,
`endif
    output out, out_q, sel_q
  );

endinterface : reg_dst_data_mux_if

// File: rtl/reg_dst_data_mux.sv
// Purpose : 4:1 write-back data selector for the register file, plus a registered copy.
// Ports   : clk, rst (sync, active-high); bus (slave modport): a,b,c,d,sel in; out, out_q, sel_q out.
// Latency : out is combinational (0 cycles); out_q/sel_q lag by exactly 1 cycle. Always ready, no handshake.
// Optional: REG_DST_DATA_MUX_ZERO_FLAG_EN adds zero (out==0) and zero_q (out_q==0, resets to 1).
module reg_dst_data_mux
  import reg_dst_data_mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  reg_dst_data_mux_if.slave bus
);

  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  sel_t             sel_d;
  sel_t             sel_q;

  // Source select. An unknown select falls into the default branch and drives
  // zeros, so a floating select never fabricates write data.
  always_comb begin
    out = '0;
    case (bus.sel)
      SEL_A:   out = bus.a;
      SEL_B:   out = bus.b;
      SEL_C:   out = bus.c;
      SEL_D:   out = bus.d;
      default: out = '0;
    endcase
  end

  // Next-state for the write-back pipeline register.
  always_comb begin
    out_d = out;
    sel_d = bus.sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      sel_q <= SEL_A;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
    end
  end

  assign bus.out   = out;
  assign bus.out_q = out_q;
  assign bus.sel_q = sel_q;

`ifdef REG_DST_DATA_MUX_ZERO_FLAG_EN
  logic zero;
  logic zero_d;
  logic zero_q;

  always_comb begin
    zero   = (out == '0);
    zero_d = zero;
  end

  // Resets to 1 so the flag agrees with the cleared out_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign bus.zero   = zero;
  assign bus.zero_q = zero_q;
`endif

endmodule : reg_dst_data_mux

// File: tb/tb_reg_dst_data_mux.sv
// Purpose : directed self-checking bench for reg_dst_data_mux.
// Ports   : none; instantiates the interface and the top, generates clk (10-unit period).
// Optional: REG_DST_DATA_MUX_ZERO_FLAG_EN enables the zero / zero_q checks.
module tb_reg_dst_data_mux;
  import reg_dst_data_mux_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  reg_dst_data_mux_if #(.WIDTH(16)) bus ();

  reg_dst_data_mux #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Watchdog: the directed sequence is a few dozen cycles long.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.a   = 16'h000A;
    bus.b   = 16'h00A0;
    bus.c   = 16'h0A00;
    bus.d   = 16'hA000;
    bus.sel = SEL_A;

    // Reset state.
    @(posedge clk); #1;
    chk("rst_out_q", bus.out_q, 16'h0000);
    chk("rst_sel_q", {14'd0, bus.sel_q}, 16'd0);
`ifdef REG_DST_DATA_MUX_ZERO_FLAG_EN
    chk("rst_zero_q", {15'd0, bus.zero_q}, 16'd1);
`endif
    rst = 1'b0;

    // Combinational selection, each value held 50 units.
    bus.sel = 2'b00; #1; chk("comb_sel00", bus.out, 16'h000A); #49;
    bus.sel = 2'b01; #1; chk("comb_sel01", bus.out, 16'h00A0); #49;
    bus.sel = 2'b10; #1; chk("comb_sel10", bus.out, 16'h0A00); #49;
    bus.sel = 2'b11; #1; chk("comb_sel11", bus.out, 16'hA000); #49;

    // Data change on the selected source between edges.
    @(negedge clk);
    bus.sel = 2'b01;
    bus.b   = 16'h1234;
    #1;
    chk("data_chg_out", bus.out, 16'h1234);
    @(posedge clk); #1;
    chk("data_chg_out_q", bus.out_q, 16'h1234);
    chk("data_chg_sel_q", {14'd0, bus.sel_q}, 16'd1);

    // Mid-operation reset: out unaffected, registers cleared.
    @(negedge clk);
    bus.sel = 2'b11;
    rst     = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_q", bus.out_q, 16'h0000);
    chk("mid_rst_sel_q", {14'd0, bus.sel_q}, 16'd0);
    chk("mid_rst_out", bus.out, 16'hA000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_out_q", bus.out_q, 16'hA000);
    chk("post_rst_sel_q", {14'd0, bus.sel_q}, 16'd3);

    // Unknown select. All sources zeroed so the expectation holds whether the
    // simulator keeps X or collapses it to some 2-state value.
    @(negedge clk);
    bus.a   = 16'h0000;
    bus.b   = 16'h0000;
    bus.c   = 16'h0000;
    bus.d   = 16'h0000;
    bus.sel = 2'bxx;
    #1;
    chk("selx_out", bus.out, 16'h0000);
    @(posedge clk); #1;
    chk("selx_out_q", bus.out_q, 16'h0000);

    // Consecutive-cycle toggle 00 -> 11: out_q lags out by one cycle.
    @(negedge clk);
    bus.a   = 16'h000A;
    bus.b   = 16'h00A0;
    bus.c   = 16'h0A00;
    bus.d   = 16'hA000;
    bus.sel = 2'b00;
    @(posedge clk); #1;
    chk("tog0_out_q", bus.out_q, 16'h000A);
    chk("tog0_sel_q", {14'd0, bus.sel_q}, 16'd0);
    bus.sel = 2'b11;
    #1;
    chk("tog1_out", bus.out, 16'hA000);
    chk("tog1_out_q_lag", bus.out_q, 16'h000A);
    @(posedge clk); #1;
    chk("tog1_out_q", bus.out_q, 16'hA000);
    chk("tog1_sel_q", {14'd0, bus.sel_q}, 16'd3);

`ifdef REG_DST_DATA_MUX_ZERO_FLAG_EN
    // Zero flags.
    @(negedge clk);
    bus.a   = 16'h0000;
    bus.sel = 2'b00;
    #1;
    chk("zero_a0", {15'd0, bus.zero}, 16'd1);
    @(posedge clk); #1;
    chk("zero_q_a0", {15'd0, bus.zero_q}, 16'd1);
    bus.sel = 2'b01;
    #1;
    chk("zero_b", {15'd0, bus.zero}, 16'd0);
    @(posedge clk); #1;
    chk("zero_q_b", {15'd0, bus.zero_q}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("zero_q_rst", {15'd0, bus.zero_q}, 16'd1);
    chk("zero_rst_comb", {15'd0, bus.zero}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_dst_data_mux
